// File: rtl/ternary_serial_alu.sv
// Bit-serial ternary ALU: one trit pair per clock, LSB first,
// through min / max / any / consensus, with a sticky illegal-code flag.
module ternary_serial_alu #(
    parameter int N_TRITS = 8,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [2*N_TRITS-1:0] a,
    input  logic [2*N_TRITS-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N_TRITS-1:0] result,
    output logic                 invalid
);
    localparam int W = 2 * N_TRITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inv_q, inv_d;

    logic [1:0] x, y, rt;
    logic [2:0] sum;
    logic       bad;
    logic       last;

    // Trit function on the current LSB pair of the shifting operands
    always_comb begin
        x   = a_q[1:0];
        y   = b_q[1:0];
        bad = (&x) | (&y);
        sum = {1'b0, x} + {1'b0, y};
        rt  = 2'b00;
        unique case (op_q)
            2'b00: rt = (x < y) ? x : y;
            2'b01: rt = (x > y) ? x : y;
            2'b10: begin
                if (sum <= 3'd1)      rt = 2'd0;
                else if (sum >= 3'd3) rt = 2'd2;
                else                  rt = 2'd1;
            end
            2'b11: begin
                if (x == 2'd0 && y == 2'd0)      rt = 2'd0;
                else if (x == 2'd2 && y == 2'd2) rt = 2'd2;
                else                             rt = 2'd1;
            end
        endcase
        if (bad) rt = 2'b00;
    end

    assign last = (cnt_q == CNT_W'(N_TRITS - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = '0;
                    inv_d   = 1'b0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = {2'b00, a_q[W-1:2]};
                b_d   = {2'b00, b_q[W-1:2]};
                res_d = {rt, res_q[W-1:2]};
                inv_d = inv_q | bad;
                if (last) state_d = DONE;
                else      cnt_d   = cnt_q + CNT_W'(1);
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign invalid   = inv_q;
endmodule
